// File: rtl/mux_lut_engine.sv
// Programmable LUT function generator: 2**SEL_W two-bit entries (0, 1, din, ~din) indexed by sel.
// Define MUX_LUT_PIPE2_EN to add a second output register stage (latency 2 instead of 1).
module mux_lut_engine #(
  parameter int SEL_W  = 3,
  parameter int CODE_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CODE_W-1:0] cfg_code,
  output logic              cfg_done,
  input  logic              in_valid,
  input  logic [SEL_W-1:0]  sel,
  input  logic              din,
  output logic              out_valid,
  output logic              f
);

  localparam int DEPTH = 2 ** SEL_W;

  typedef enum logic [1:0] {
    ST_UNCFG,
    ST_LOAD,
    ST_RUN
  } state_t;

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  idx;
  logic [CODE_W-1:0] lut [DEPTH];
  logic              cfg_acc;
  logic              last_acc;
  logic              eval_acc;
  logic              vld_p1;
  logic              f_p1;

  function automatic logic decode(input logic [CODE_W-1:0] code, input logic d);
    logic r;
    case (code)
      2'b00:   r = 1'b0;
      2'b01:   r = 1'b1;
      2'b10:   r = d;
      default: r = ~d;
    endcase
    return r;
  endfunction

  always_comb begin
    // A restart pulse in LOAD blocks the handshake so the beat cannot land at the old index.
    cfg_ready = (state == ST_LOAD) && !cfg_start;
    cfg_acc   = cfg_valid && cfg_ready;
    last_acc  = cfg_acc && (idx == {SEL_W{1'b1}});
    eval_acc  = in_valid && (state == ST_RUN) && !cfg_start;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_UNCFG: if (cfg_start) state_nxt = ST_LOAD;
      ST_LOAD:  if (!cfg_start && last_acc) state_nxt = ST_RUN;
      ST_RUN:   if (cfg_start) state_nxt = ST_LOAD;
      default:  state_nxt = ST_UNCFG;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_UNCFG;
      idx      <= '0;
      cfg_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cfg_done <= last_acc;
      if (cfg_start)
        idx <= '0;
      else if (cfg_acc)
        idx <= idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        lut[i] <= '0;
    end else if (cfg_acc) begin
      lut[idx] <= cfg_code;
    end
  end

  // Stage p1: table lookup and decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      f_p1   <= 1'b0;
    end else begin
      vld_p1 <= eval_acc;
      if (eval_acc)
        f_p1 <= decode(lut[sel], din);
    end
  end

`ifdef MUX_LUT_PIPE2_EN
  logic vld_p2;
  logic f_p2;

  // Stage p2: output retime; runs freely so in-flight results survive a reload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      f_p2   <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1)
        f_p2 <= f_p1;
    end
  end

  assign out_valid = vld_p2;
  assign f         = f_p2;
`else
  assign out_valid = vld_p1;
  assign f         = f_p1;
`endif

endmodule

// File: tb/tb_mux_lut_engine.sv
// Directed bench for mux_lut_engine: default SEL_W=3 instance plus a SEL_W=4 instance.
module tb_mux_lut_engine;

`ifdef MUX_LUT_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       cfg_start, cfg_valid, cfg_ready, cfg_done;
  logic [1:0] cfg_code;
  logic       in_valid, din, out_valid, f;
  logic [2:0] sel;

  logic       cfg_start4, cfg_valid4, cfg_ready4, cfg_done4;
  logic [1:0] cfg_code4;
  logic       in_valid4, din4, out_valid4, f4;
  logic [3:0] sel4;

  mux_lut_engine #(.SEL_W(3), .CODE_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_code(cfg_code), .cfg_done(cfg_done),
    .in_valid(in_valid), .sel(sel), .din(din), .out_valid(out_valid), .f(f)
  );

  mux_lut_engine #(.SEL_W(4), .CODE_W(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start4), .cfg_valid(cfg_valid4),
    .cfg_ready(cfg_ready4), .cfg_code(cfg_code4), .cfg_done(cfg_done4),
    .in_valid(in_valid4), .sel(sel4), .din(din4), .out_valid(out_valid4), .f(f4)
  );

  typedef struct {
    logic [2:0] sel;
    logic       din;
    logic       exp_f;
  } vec_t;

  vec_t vecs[24];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Eight load beats; cw[2*i+1:2*i] is the code for entry i; optional idle beat after entry gap_after.
  task automatic load8(input logic [15:0] cw, input int gap_after);
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1;
      cfg_code  = cw[2*i +: 2];
      #1;
      check($sformatf("cfg_ready beat%0d", i), cfg_ready, 1'b1);
      step();
      check($sformatf("cfg_done beat%0d", i), cfg_done, i == 7);
      if (i == gap_after) begin
        cfg_valid = 1'b0;
        step();
        check("cfg_done gap", cfg_done, 1'b0);
      end
    end
    cfg_valid = 1'b0;
    step();
    check("cfg_done single pulse", cfg_done, 1'b0);
    check("cfg_ready in run", cfg_ready, 1'b0);
  endtask

  task automatic run_vecs(input int first, input int n);
    for (int j = 0; j < n + LAT - 1; j++) begin
      if (j < n) begin
        in_valid = 1'b1;
        sel      = vecs[first + j].sel;
        din      = vecs[first + j].din;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (j >= LAT - 1) begin
        check($sformatf("out_valid vec%0d", first + j - LAT + 1), out_valid, 1'b1);
        check($sformatf("f vec%0d", first + j - LAT + 1), f, vecs[first + j - LAT + 1].exp_f);
      end
    end
    in_valid = 1'b0;
    step();
    check("out_valid idle", out_valid, 1'b0);
    check("f holds", f, vecs[first + n - 1].exp_f);
  endtask

  initial begin
    // Table 0,0,1,1,1,0,1,~din swept with din=0 then din=1; then table ~d,d,1,0,~d,d,1,0.
    vecs = '{
      '{3'd0, 1'b0, 1'b0}, '{3'd1, 1'b0, 1'b0}, '{3'd2, 1'b0, 1'b1}, '{3'd3, 1'b0, 1'b1},
      '{3'd4, 1'b0, 1'b1}, '{3'd5, 1'b0, 1'b0}, '{3'd6, 1'b0, 1'b1}, '{3'd7, 1'b0, 1'b1},
      '{3'd0, 1'b1, 1'b0}, '{3'd1, 1'b1, 1'b0}, '{3'd2, 1'b1, 1'b1}, '{3'd3, 1'b1, 1'b1},
      '{3'd4, 1'b1, 1'b1}, '{3'd5, 1'b1, 1'b0}, '{3'd6, 1'b1, 1'b1}, '{3'd7, 1'b1, 1'b0},
      '{3'd0, 1'b1, 1'b0}, '{3'd1, 1'b1, 1'b1}, '{3'd2, 1'b1, 1'b1}, '{3'd3, 1'b1, 1'b0},
      '{3'd4, 1'b0, 1'b1}, '{3'd5, 1'b0, 1'b0}, '{3'd6, 1'b0, 1'b1}, '{3'd7, 1'b0, 1'b0}
    };

    rst_n = 1'b0;
    cfg_start = 1'b0; cfg_valid = 1'b0; cfg_code = 2'b00;
    in_valid = 1'b0; sel = '0; din = 1'b0;
    cfg_start4 = 1'b0; cfg_valid4 = 1'b0; cfg_code4 = 2'b00;
    in_valid4 = 1'b0; sel4 = '0; din4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset cfg_ready", cfg_ready, 1'b0);
    check("reset cfg_done", cfg_done, 1'b0);
    check("reset out_valid", out_valid, 1'b0);
    check("reset f", f, 1'b0);

    // Unconfigured engine ignores inputs
    in_valid = 1'b1; sel = 3'd2; din = 1'b1;
    step();
    check("uncfg out_valid", out_valid, 1'b0);
    step();
    check("uncfg out_valid2", out_valid, 1'b0);
    check("uncfg f", f, 1'b0);
    in_valid = 1'b0;

    // Start pulse with a simultaneous beat: that beat must not be taken
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_code = 2'b11;
    #1;
    check("cfg_ready uncfg start", cfg_ready, 1'b0);
    step();
    cfg_start = 1'b0;
    load8(16'hD150, -1);
    run_vecs(0, 16);

    // Partial reload, restart after three accepted entries, then full load with a gap
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    cfg_valid = 1'b1; cfg_code = 2'b01; step();
    cfg_valid = 1'b0; step();
    cfg_valid = 1'b1; step();
    step();
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_code = 2'b11;
    #1;
    check("cfg_ready during restart", cfg_ready, 1'b0);
    step();
    cfg_start = 1'b0;
    check("cfg_done after restart", cfg_done, 1'b0);
    load8(16'h1B1B, 3);
    run_vecs(16, 8);

    // Accepted input followed by a reload pulse that collides with a second input
    in_valid = 1'b1; sel = 3'd4; din = 1'b0;
    step();
`ifndef MUX_LUT_PIPE2_EN
    check("pre-reload out_valid", out_valid, 1'b1);
    check("pre-reload f", f, 1'b1);
`endif
    cfg_start = 1'b1; sel = 3'd0; din = 1'b1;
    step();
    cfg_start = 1'b0; in_valid = 1'b0;
`ifdef MUX_LUT_PIPE2_EN
    check("inflight out_valid", out_valid, 1'b1);
`else
    check("collide out_valid", out_valid, 1'b0);
`endif
    check("collide f", f, 1'b1);
    step();
    check("dropped out_valid", out_valid, 1'b0);
    check("dropped f", f, 1'b1);
    check("cfg_ready after reload", cfg_ready, 1'b1);

    // Asynchronous reset in the middle of a load
    cfg_valid = 1'b1; cfg_code = 2'b01;
    step();
    step();
    cfg_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async rst cfg_ready", cfg_ready, 1'b0);
    check("async rst cfg_done", cfg_done, 1'b0);
    check("async rst out_valid", out_valid, 1'b0);
    check("async rst f", f, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b1; sel = 3'd3; din = 1'b1;
    step();
    check("post-rst out_valid", out_valid, 1'b0);
    step();
    check("post-rst out_valid2", out_valid, 1'b0);
    check("post-rst f", f, 1'b0);
    in_valid = 1'b0;

    // SEL_W=4 instance: every entry is din
    cfg_start4 = 1'b1;
    step();
    cfg_start4 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cfg_valid4 = 1'b1; cfg_code4 = 2'b10;
      step();
      check($sformatf("w4 cfg_done beat%0d", i), cfg_done4, i == 15);
    end
    cfg_valid4 = 1'b0;
    for (int j = 0; j < 16 + LAT - 1; j++) begin
      if (j < 16) begin
        in_valid4 = 1'b1;
        sel4      = 4'(j);
        din4      = (j % 3 == 0);
      end else begin
        in_valid4 = 1'b0;
      end
      step();
      if (j >= LAT - 1) begin
        check($sformatf("w4 out_valid sel%0d", j - LAT + 1), out_valid4, 1'b1);
        check($sformatf("w4 f sel%0d", j - LAT + 1), f4, ((j - LAT + 1) % 3 == 0));
      end
    end
    in_valid4 = 1'b0;
    step();
    check("w4 out_valid idle", out_valid4, 1'b0);
    check("w4 cfg_ready run", cfg_ready4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
